time_entry: RTL
===============

TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port clr  input  1  synchronous, active-high reset.
REQ-003 SHALL have port key_valid  input  1  one-cycle strobe: key_digit holds a new keypad digit.
REQ-004 SHALL have port key_digit  input  4  BCD digit 0-9; values 10-15 are illegal.
REQ-005 SHALL have port start  input  1  level, sampled each cycle: request to begin cooking.
REQ-006 SHALL have port cancel  input  1  level, sampled each cycle: abort entry or cooking.
REQ-007 SHALL have port timer_done  input  1  zero indication from the downstream minutes/sec-tens/sec-ones down-counter chain.
REQ-008 SHALL have port min_data  output  4  minutes digit to timer load input.
REQ-009 SHALL have port sec_tens_data  output  4  seconds-tens digit to the mod-6 stage load input.
REQ-010 SHALL have port sec_ones_data  output  4  seconds-ones digit to timer load input.
REQ-011 SHALL have port loadn  output  1  active-low one-cycle load strobe to all timer digits.
REQ-012 SHALL have port run  output  1  count enable to the timer chain.
REQ-013 SHALL have port entry_err  output  1  one-cycle pulse flagging a rejected key or start.

Function
REQ-014 SHALL implement FSM states IDLE, ENTRY, LOAD, RUN.
REQ-015 SHALL, on an accepted key, shift digits: min<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit, and increment digit count (0..3).
REQ-016 SHALL accept a key only in IDLE or ENTRY; IDLE+key -> ENTRY with count=1.
REQ-017 SHALL reject a key with key_digit>9, or with count=3, by leaving digits unchanged and pulsing entry_err in the next cycle.
REQ-018 SHALL ignore key_valid in LOAD and RUN without raising entry_err.
REQ-019 SHALL, on start in ENTRY, enter LOAD only if sec_tens<=5 and not all digits are zero; otherwise it SHALL stay in ENTRY and pulse entry_err.
REQ-020 SHALL ignore start in IDLE, LOAD and RUN.
REQ-021 SHALL give start priority over key_valid in the same cycle: the key is discarded and no error is flagged for it.
REQ-022 SHALL give cancel priority over every other input: in ENTRY, LOAD or RUN it SHALL clear the digits and count and return to IDLE on the next edge.
REQ-023 SHALL drive loadn=0 for exactly the one cycle spent in LOAD, and loadn=1 at all other times.
REQ-024 SHALL have latency: start sampled at edge N -> loadn=0 during cycle N+1 -> run=1 from cycle N+2.
REQ-025 SHALL hold digit outputs stable from LOAD through RUN.
REQ-026 SHALL drive run=1 only in RUN.
REQ-027 SHALL, in RUN, move to IDLE and clear the digits when timer_done=1 is sampled; run deasserts in the following cycle.
REQ-028 SHALL ignore timer_done outside RUN.

Reset
REQ-029 SHALL, with clr=1 at a clock edge, set state=IDLE, all digits=0, count=0, loadn=1, run=0, entry_err=0.
REQ-030 SHALL let clr override cancel, start and key_valid, including mid-LOAD or mid-RUN.

Structure
REQ-031 SHALL take state encoding, DIGIT_W=4, MAX_DIGITS=3 and SEC_TENS_MAX=5 from the shared microwave package.
REQ-032 SHALL place the 3-digit shift register and count in one sub-module, digit_shift_reg; the FSM and validation stay in time_entry.

Verification
REQ-033 SHALL cover keys 1,3,0 then start: digits 1/3/0, loadn low one cycle at N+1, run=1 from N+2, and run drops one cycle after timer_done=1.
REQ-034 SHALL cover keys 1,7,0 then start: entry_err pulses, state stays ENTRY, loadn stays 1, run stays 0.
REQ-035 SHALL cover keys 1,2,3 then key 4: digits stay 1/2/3 and entry_err pulses; key 0xB in ENTRY: digits unchanged and entry_err pulses.
REQ-036 SHALL cover key 5 then start and key_valid (digit 9) together: digits 0/0/5 and LOAD entered; key 0 then start: entry_err pulses, no load.
REQ-037 SHALL cover cancel in RUN: run drops next cycle and digits clear to 0/0/0; clr asserted in LOAD: next cycle loadn=1, run=0, state IDLE.

Source files
------------

// File: rtl/microwave_pkg.sv
// microwave_pkg: shared widths, limits, FSM state codes and digit helper for the microwave timer blocks
//   DIGIT_W      - width of one BCD digit
//   MAX_DIGITS   - number of digits the entry register holds
//   SEC_TENS_MAX - largest legal seconds-tens digit
//   ST_*         - time_entry state encoding
package microwave_pkg;
    localparam int DIGIT_W = 4;
    localparam logic [1:0] MAX_DIGITS = 2'd3;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ENTRY = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;
    function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
        return d <= 4'd9;
    endfunction
endpackage

// File: rtl/digit_shift_reg.sv
// digit_shift_reg: three-digit keypad shift register with entered-digit count
//   clock, clr     - clock and synchronous active-high reset
//   clear          - synchronous clear of digits and count
//   shift, din     - shift din in at the ones position, older digits move left
//   min_d, tens_d, ones_d - held digits
//   count          - number of digits entered so far (0..3)
module digit_shift_reg
    import microwave_pkg::*;
(
    input  logic               clock,
    input  logic               clr,
    input  logic               clear,
    input  logic               shift,
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] min_d,
    output logic [DIGIT_W-1:0] tens_d,
    output logic [DIGIT_W-1:0] ones_d,
    output logic [1:0]         count
);
    always_ff @(posedge clock) begin
        if (clr || clear) begin
            min_d  <= '0;
            tens_d <= '0;
            ones_d <= '0;
            count  <= '0;
        end else if (shift) begin
            min_d  <= tens_d;
            tens_d <= ones_d;
            ones_d <= din;
            count  <= count + 2'd1;
        end
    end
endmodule

// File: rtl/time_entry.sv
// time_entry: keypad time entry FSM that validates M:SS digits and loads/starts the countdown timer
//   clock, clr        - clock and synchronous active-high reset
//   key_valid, key_digit - keypad digit strobe and BCD value
//   start, cancel     - level requests to begin cooking / abort
//   timer_done        - downstream countdown reached zero
//   min_data, sec_tens_data, sec_ones_data - digits to the timer load inputs
//   loadn             - active-low load strobe, low only in LOAD
//   run               - timer count enable, high only in RUN
//   entry_err         - one-cycle pulse for a rejected key or start
module time_entry
    import microwave_pkg::*;
(
    input  logic               clock,
    input  logic               clr,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               start,
    input  logic               cancel,
    input  logic               timer_done,
    output logic [DIGIT_W-1:0] min_data,
    output logic [DIGIT_W-1:0] sec_tens_data,
    output logic [DIGIT_W-1:0] sec_ones_data,
    output logic               loadn,
    output logic               run,
    output logic               entry_err
);
    logic [1:0] state, state_n, count;
    logic take_start, start_ok, key_seen, key_bad, shift, clear, err_n;

    // start is only honoured in ENTRY, where it also swallows a coincident key
    assign take_start = state == ST_ENTRY && start;
    assign start_ok   = sec_tens_data <= SEC_TENS_MAX && {min_data, sec_tens_data, sec_ones_data} != '0;
    assign key_seen   = key_valid && (state == ST_IDLE || state == ST_ENTRY) && !take_start;
    assign key_bad    = !is_bcd(key_digit) || count == MAX_DIGITS;
    assign shift      = !cancel && key_seen && !key_bad;
    assign clear      = cancel || (state == ST_RUN && timer_done);
    assign err_n      = !cancel && ((key_seen && key_bad) || (take_start && !start_ok));

    always_comb begin
        state_n = cancel ? ST_IDLE :
                  take_start ? (start_ok ? ST_LOAD : ST_ENTRY) :
                  shift ? ST_ENTRY :
                  state == ST_LOAD ? ST_RUN :
                  (state == ST_RUN && timer_done) ? ST_IDLE : state;
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            state     <= ST_IDLE;
            entry_err <= 1'b0;
        end else begin
            state     <= state_n;
            entry_err <= err_n;
        end
    end

    digit_shift_reg u_digits (
        .clock (clock),
        .clr   (clr),
        .clear (clear),
        .shift (shift),
        .din   (key_digit),
        .min_d (min_data),
        .tens_d(sec_tens_data),
        .ones_d(sec_ones_data),
        .count (count)
    );

    assign loadn = state != ST_LOAD;
    assign run   = state == ST_RUN;
endmodule
